// File: rtl/booth_pkg.sv
// Shared constants for the radix-2 Booth multiply step: default operand width and op codes.
package booth_pkg;

  localparam int unsigned WIDTH = 8;

  typedef logic [1:0] op_t;

  localparam op_t OP_NONE = 2'b00;
  localparam op_t OP_ADD  = 2'b01;
  localparam op_t OP_SUB  = 2'b10;

endpackage

// File: rtl/booth_step_comb.sv
// Combinational Booth datapath: select add/sub/skip from q_in[1:0], then arithmetic-shift {S,Q} right.
// Optional op port exists only when BOOTH_STEP_OP_EN is defined.
module booth_step_comb #(
  parameter int unsigned WIDTH = booth_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] m_in,
  input  logic [WIDTH:0]   q_in,
  output logic [WIDTH-1:0] a_next,
  output logic [WIDTH:0]   q_next
`ifdef BOOTH_STEP_OP_EN
  ,
  output logic [1:0]       op
`endif
);

  import booth_pkg::*;

  op_t              op_sel;
  logic [WIDTH-1:0] sum;

  // Booth recoding of the current bit pair.
  always_comb begin
    op_sel = OP_NONE;
    case (q_in[1:0])
      2'b01:   op_sel = OP_ADD;
      2'b10:   op_sel = OP_SUB;
      default: op_sel = OP_NONE;
    endcase
  end

  // Modulo-2^WIDTH add/sub; carry and overflow are intentionally dropped.
  always_comb begin
    sum = a_in;
    case (op_sel)
      OP_ADD:  sum = WIDTH'(a_in + m_in);
      OP_SUB:  sum = WIDTH'(a_in - m_in);
      default: sum = a_in;
    endcase
    a_next = {sum[WIDTH-1], sum[WIDTH-1:1]};
    q_next = {sum[0], q_in[WIDTH:1]};
  end

`ifdef BOOTH_STEP_OP_EN
  assign op = op_sel;
`endif

endmodule

// File: rtl/booth_step.sv
// One pipelined radix-2 Booth step; chain WIDTH of these for a WIDTH x WIDTH signed multiplier.
// Defining BOOTH_STEP_OP_EN adds the registered op_out port.
module booth_step #(
  parameter int unsigned WIDTH = booth_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] m_in,
  input  logic [WIDTH:0]   q_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH:0]   q_out,
  output logic [WIDTH-1:0] m_out
`ifdef BOOTH_STEP_OP_EN
  ,
  output logic [1:0]       op_out
`endif
);

  logic [WIDTH-1:0] a_next;
  logic [WIDTH:0]   q_next;
`ifdef BOOTH_STEP_OP_EN
  logic [1:0]       op_c;
`endif

  booth_step_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .a_in   (a_in),
    .m_in   (m_in),
    .q_in   (q_in),
    .a_next (a_next),
    .q_next (q_next)
`ifdef BOOTH_STEP_OP_EN
    ,
    .op     (op_c)
`endif
  );

  // Data loads every cycle; consumers qualify it with out_valid. Reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      a_out     <= '0;
      q_out     <= '0;
      m_out     <= '0;
    end else begin
      out_valid <= in_valid;
      a_out     <= a_next;
      q_out     <= q_next;
      m_out     <= m_in;
    end
  end

`ifdef BOOTH_STEP_OP_EN
  always_ff @(posedge clk) begin
    if (rst) op_out <= 2'b00;
    else     op_out <= op_c;
  end
`endif

endmodule

// File: tb/tb_booth_step.sv
// Bench for booth_step: single-step vectors on stage 1 plus a WIDTH-stage chained multiplier
// checked against a product scoreboard.
module tb_booth_step;

  import booth_pkg::*;

  localparam int unsigned W = WIDTH;

  logic clk = 1'b0;
  logic rst;
  logic in_v;
  logic [W-1:0] in_a;
  logic [W-1:0] in_m;
  logic [W:0]   in_q;

  logic         v_s [W+1];
  logic [W-1:0] a_s [W+1];
  logic [W-1:0] m_s [W+1];
  logic [W:0]   q_s [W+1];
`ifdef BOOTH_STEP_OP_EN
  logic [1:0]   op_s [1:W];
`endif

  logic [2*W-1:0] prod;
  logic [2*W-1:0] exp_q [$];

  int vectors = 0;
  int errors  = 0;
  int cyc = 0;
  int valid_cycles = 0;
  int first_cyc = -1;
  int last_cyc = -1;
  int t0;

  always #5 clk = ~clk;

  assign v_s[0] = in_v;
  assign a_s[0] = in_a;
  assign m_s[0] = in_m;
  assign q_s[0] = in_q;
  assign prod   = {a_s[W], q_s[W][W:1]};

  for (genvar i = 0; i < W; i++) begin : g_stage
    booth_step #(
      .WIDTH (W)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (v_s[i]),
      .a_in      (a_s[i]),
      .m_in      (m_s[i]),
      .q_in      (q_s[i]),
      .out_valid (v_s[i+1]),
      .a_out     (a_s[i+1]),
      .q_out     (q_s[i+1]),
      .m_out     (m_s[i+1])
`ifdef BOOTH_STEP_OP_EN
      ,
      .op_out    (op_s[i+1])
`endif
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, expv);
      $error("check %s did not hold", tag);
    end
  endtask

  // Advance one edge, sample #1 later, and retire any product reaching the last stage.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (v_s[W] === 1'b1) begin
      valid_cycles++;
      last_cyc = cyc;
      if (first_cyc < 0) first_cyc = cyc;
      check("product_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("product", 32'(prod), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic drive_chain(input logic [W-1:0] m, input logic [W-1:0] mult);
    int pm;
    in_v = 1'b1;
    in_a = '0;
    in_m = m;
    in_q = {mult, 1'b0};
    pm = int'($signed(m)) * int'($signed(mult));
    exp_q.push_back((2*W)'(pm));
  endtask

  task automatic drain();
    for (int k = 0; k < 4 * W && exp_q.size() != 0; k++) step();
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_all_reset();
    for (int i = 1; i <= W; i++) begin
      check($sformatf("rst_valid_s%0d", i), 32'(v_s[i]), 32'd0);
      check($sformatf("rst_a_s%0d", i), 32'(a_s[i]), 32'd0);
      check($sformatf("rst_q_s%0d", i), 32'(q_s[i]), 32'd0);
      check($sformatf("rst_m_s%0d", i), 32'(m_s[i]), 32'd0);
`ifdef BOOTH_STEP_OP_EN
      check($sformatf("rst_op_s%0d", i), 32'(op_s[i]), 32'd0);
`endif
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    in_v = 1'b0;
    in_a = '0;
    in_m = '0;
    in_q = '0;
    step();
    check_all_reset();
    rst = 1'b0;

    // Single-step vectors on stage 1.
    in_v = 1'b1; in_a = 8'h00; in_m = 8'h05; in_q = 9'h00C;
    step();
    check("noop_valid", 32'(v_s[1]), 32'd1);
    check("noop_a", 32'(a_s[1]), 32'h00);
    check("noop_q", 32'(q_s[1]), 32'h006);
    check("noop_m", 32'(m_s[1]), 32'h05);
`ifdef BOOTH_STEP_OP_EN
    check("noop_op", 32'(op_s[1]), 32'(OP_NONE));
`endif

    in_a = 8'h00; in_m = 8'h05; in_q = 9'h006;
    step();
    check("sub_a", 32'(a_s[1]), 32'hFD);
    check("sub_q", 32'(q_s[1]), 32'h103);
`ifdef BOOTH_STEP_OP_EN
    check("sub_op", 32'(op_s[1]), 32'(OP_SUB));
`endif

    in_a = 8'h7F; in_m = 8'h01; in_q = 9'h001;
    step();
    check("wrap_a", 32'(a_s[1]), 32'hC0);
    check("wrap_q", 32'(q_s[1]), 32'h000);
`ifdef BOOTH_STEP_OP_EN
    check("wrap_op", 32'(op_s[1]), 32'(OP_ADD));
`endif

    in_a = 8'h00; in_m = 8'h80; in_q = 9'h002;
    step();
    check("minm_a", 32'(a_s[1]), 32'hC0);
    check("minm_q", 32'(q_s[1]), 32'h001);
    check("minm_m", 32'(m_s[1]), 32'h80);

    // Reset with valid tokens in flight.
    rst = 1'b1; in_v = 1'b0;
    step();
    check_all_reset();
    rst = 1'b0;

    // Single chained product with latency check.
    drive_chain(8'h05, 8'h06);
    step();
    t0 = cyc;
    in_v = 1'b0;
    drain();
    check("chain_latency", 32'(last_cyc - t0), 32'(W - 1));

    // Back-to-back streaming of the four sign cases.
    valid_cycles = 0;
    first_cyc = -1;
    drive_chain(8'h05, 8'h06); step();
    drive_chain(8'hFB, 8'h06); step();
    drive_chain(8'hFB, 8'hFA); step();
    drive_chain(8'h05, 8'hFA); step();
    in_v = 1'b0;
    drain();
    repeat (3) step();
    check("stream_valid_cycles", 32'(valid_cycles), 32'd4);
    check("stream_consecutive", 32'(last_cyc - first_cyc), 32'd3);

    // Reset mid-stream, then a fresh product.
    drive_chain(8'h05, 8'hFA); step();
    drive_chain(8'hFB, 8'h06); step();
    in_v = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    check_all_reset();
    exp_q.delete();
    rst = 1'b0;
    drive_chain(8'hFB, 8'hFA);
    step();
    in_v = 1'b0;
    drain();
    repeat (W + 2) step();
    check("post_reset_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
